// File: rtl/result_uart_pkg.sv
// Shared types and constants for the result UART transmitter.
package result_uart_pkg;
  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;
endpackage

// File: rtl/result_uart_tx_baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the last count.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_done = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || bit_done) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/result_uart_tx.sv
// Byte UART transmitter (start, 8 data LSB first, optional even parity, stop).
// Parity bit enabled by defining RESULT_UART_TX_PARITY_EN.
module result_uart_tx
  import result_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);
  localparam int IDX_W = $clog2(DATA_BITS);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 bit_done;
  logic                 restart;
  logic                 accept;
`ifdef RESULT_UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .bit_done(bit_done)
  );

  // A held valid at the end of a stop bit chains the next frame with no idle cycle.
  assign accept  = valid && (ready_q || (state_q == STOP && bit_done));
  assign restart = (state_q == IDLE) || (state_d != state_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
`ifdef RESULT_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
`ifdef RESULT_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
`ifdef RESULT_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE:  ;
      START: if (bit_done) state_d = DATA;
      DATA: begin
        if (bit_done) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef RESULT_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef RESULT_UART_TX_PARITY_EN
      PARITY: if (bit_done) state_d = STOP;
`endif
      STOP:    if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d  = START;
      shift_d  = data_in;
      idx_d    = '0;
`ifdef RESULT_UART_TX_PARITY_EN
      parity_d = ^data_in;
`endif
    end
  end

  // Outputs are computed from the next state so that they are registered yet aligned with it.
  always_comb begin
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef RESULT_UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign tx    = tx_q;
  assign busy  = busy_q;
  assign ready = ready_q;
endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx with CLKS_PER_BIT = 4.
module tb_result_uart_tx;
  localparam int C = 4;
`ifdef RESULT_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 10 + P;
  localparam int F     = NBITS * C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid = 1'b0;
  logic       ready, tx, busy;
  int         checks = 0;
  int         errors = 0;

  result_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk    (clk),
    .reset  (reset),
    .data_in(data_in),
    .valid  (valid),
    .ready  (ready),
    .tx     (tx),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: value of serial bit n of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int n);
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
    if (P == 1 && n == 9) return ^b;
    return 1'b1;
  endfunction

  // Called #1 after the accept edge; checks every cycle and returns #1 after edge k+F.
  task automatic check_frame(input logic [7:0] b, input string name);
    logic exp;
    for (int j = 1; j <= F; j++) begin
      exp = frame_bit(b, (j - 1) / C);
      checks++;
      if (tx !== exp) begin
        errors++;
        $display("FAIL %s tx cycle %0d: got %b want %b", name, j, tx, exp);
      end
      checks++;
      if (busy !== 1'b1 || ready !== 1'b0) begin
        errors++;
        $display("FAIL %s busy/ready cycle %0d: got %b/%b want 1/0", name, j, busy, ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle tx/busy/ready: got %b/%b/%b want 1/0/1", name, tx, busy, ready);
    end
  endtask

  // Waits (bounded) for ready, then presents b for one accepting edge.
  task automatic accept_byte(input logic [7:0] b, input bit hold, input string name);
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s wait_ready: got %b want 1", name, ready);
    end
    data_in = b;
    valid   = 1'b1;
    @(posedge clk); #1;
    if (!hold) valid = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    valid   = 1'b1;
    data_in = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold tx/busy/ready: got %b/%b/%b want 1/0/0", tx, busy, ready);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    valid = 1'b0;
    check_idle("reset_release");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_idle("reset_no_frame");
    end
  endtask

  task automatic test_single();
    accept_byte(8'hA5, 1'b0, "single");
    check_frame(8'hA5, "single_a5");
    check_idle("single_end");
  endtask

  task automatic test_back_to_back();
    accept_byte(8'h00, 1'b1, "b2b");
    data_in = 8'hFF;
    check_frame(8'h00, "b2b_first");
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_start tx/busy/ready: got %b/%b/%b want 0/1/0", tx, busy, ready);
    end
    valid = 1'b0;
    check_frame(8'hFF, "b2b_second");
    check_idle("b2b_end");
  endtask

  task automatic test_ignore_busy();
    accept_byte(8'h81, 1'b0, "ignore");
    fork
      check_frame(8'h81, "ignore_81");
      begin
        repeat (9) @(posedge clk);
        #2;
        data_in = 8'h3C;
        valid   = 1'b1;
        @(posedge clk); #2;
        valid   = 1'b0;
      end
    join
    check_idle("ignore_end");
    for (int i = 0; i < 2 * F; i++) begin
      @(posedge clk); #1;
      check_idle("ignore_no_second");
    end
  endtask

  task automatic test_reset_mid();
    accept_byte(8'($urandom), 1'b0, "rmid");
    repeat (16) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL rmid_abort tx/busy/ready: got %b/%b/%b want 1/0/0", tx, busy, ready);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle("rmid_release");
    accept_byte(8'h55, 1'b0, "rmid_55");
    check_frame(8'h55, "rmid_55");
    check_idle("rmid_end");
  endtask

  task automatic test_parity();
    accept_byte(8'h07, 1'b0, "par07");
    check_frame(8'h07, "par_07");
    check_idle("par07_end");
    accept_byte(8'h03, 1'b0, "par03");
    check_frame(8'h03, "par_03");
    check_idle("par03_end");
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      b = 8'($urandom);
      accept_byte(b, 1'b0, "rand");
      check_frame(b, "rand_frame");
      check_idle("rand_end");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_parity();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_uart_tx.md
# result_uart_tx

Byte-wide UART transmitter that serialises the 8-bit result of the design's clocked logic unit onto a single output pin of the Tiny Tapeout wrapper. The logic unit's result is a parallel byte on `uo_out`; this block carries the same byte the other way, off-chip over one wire, so a host can capture results with a standard serial receiver. It is instantiated inside `tt_um_*`:

- Input side: the result byte plus a valid strobe.
- Output side: `tx`, driven to one `uo_out` bit.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200). Legal range is ≥ 2.
- `CNT_W`, default `$clog2(CLKS_PER_BIT)`: width of the baud counter. Derived; do not override.

Ports:
- `clk`, input, 1: the single clock. Everything is rising-edge.
- `reset`, input, 1: synchronous, active-high reset.
- `data_in`, input, 8: byte to send. Sampled only on an accepting edge.
- `valid`, input, 1: request to send `data_in`.
- `ready`, output, 1: block can accept a byte. Registered.
- `tx`, output, 1: serial line. Idles high. Registered.
- `busy`, output, 1: a frame is in progress. Registered.

## Operation
- Frame format, LSB first:
  - 1 start bit (0)
  - 8 data bits
  - optional parity bit (see Configuration)
  - 1 stop bit (1)
- Handshake:
  - A byte is accepted on a rising edge where `valid && ready`.
  - `data_in` is copied into an internal shift register on that edge.
  - `valid` is ignored when `ready` = 0. Changes to `data_in` during a frame have no effect.
- States and transitions:
  - IDLE → START on accept.
  - START → DATA after one bit time.
  - DATA → PARITY (if enabled) or STOP after 8 bit times. The bit index counts 0..7.
  - PARITY → STOP after one bit time.
  - STOP → IDLE after one bit time.
- Baud counter:
  - Loads 0 on every state entry.
  - Counts 0..`CLKS_PER_BIT`-1.
  - The bit advances on the cycle where the count equals `CLKS_PER_BIT`-1.
- Output values by state:
  - `ready` = 1 only in IDLE, and not while `reset` is high.
  - `busy` = 1 in START, DATA, PARITY and STOP.
  - `tx` = 1 in IDLE and STOP, 0 in START, the current shift-register LSB in DATA, and the parity bit in PARITY.
- Reset values: state IDLE, `tx` = 1, `busy` = 0, `ready` = 0, counters 0, shift register 0. `ready` rises on the first edge with `reset` low.
- Reset mid-frame:
  - The frame is aborted at that edge and `tx` returns to 1.
  - No partial-frame resumption.
- `valid` asserted on the same edge that reset deasserts is not accepted, because `ready` is still 0.

## Timing
- Accept at edge k: `ready`/`busy` change at k. `tx` falls at k, so the start bit is visible in cycle k+1.
- Frame length is F = (10 + P) × `CLKS_PER_BIT` cycles, where P = 1 if parity is enabled, else 0.
- `tx` returns to idle, `busy` falls and `ready` rises at edge k + F.
- Back-to-back:
  - Next accept is possible at edge k + F, if `valid` is held.
  - This gives an accept-to-accept spacing of exactly F. There are no idle gap cycles between frames.
- Bit n (start = 0) occupies cycles k+1+n·`CLKS_PER_BIT` through k+(n+1)·`CLKS_PER_BIT`.

## Configuration
- Macro: `RESULT_UART_TX_PARITY_EN`.
- Defined:
  - Adds the PARITY state and one bit time per frame.
  - Parity is even: the XOR of the 8 data bits, computed from `data_in` at accept and held in a register.
- Undefined:
  - No PARITY state, no parity register.
  - DATA goes straight to STOP and F = 10 × `CLKS_PER_BIT`.

## Structure
- Shared package `result_uart_pkg`:
  - state enum `tx_state_t` (IDLE, START, DATA, PARITY, STOP)
  - `DATA_BITS` = 8
  - `DEFAULT_CLKS_PER_BIT` = 434
- One sub-module, `uart_baud_gen`. It holds the baud counter: input `restart`, output `bit_done` (one-cycle pulse at count `CLKS_PER_BIT`-1), parameterised by `CLKS_PER_BIT`.
- The FSM, shift register and output registers stay in `result_uart_tx`.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4.
- Reset: hold `reset` for 3 cycles with `valid` = 1 → `tx` = 1, `busy` = 0 and `ready` = 0 throughout; `ready` = 1 one edge after release; no frame starts until `valid` is seen while `ready` = 1.
- Single byte 0xA5 accepted at edge k (no parity) → sampling mid-bit, `tx` reads 0,1,0,1,0,0,1,0,1,1; `busy` is high for 40 cycles; `ready` returns at k+40.
- Back-to-back: `valid` held with 0x00 then 0xFF → second accept at exactly k+40; `tx` stays high from the end of the first stop bit only through the second frame's first cycle boundary, with no extra idle cycles.
- Ignore while busy: pulse `valid` with 0x3C at k+10 during a 0x81 frame → only 0x81 is transmitted; no second frame starts.
- Reset mid-frame: assert `reset` at k+17 → `tx` = 1 and `busy` = 0 from that edge on; a new 0x55 sent afterwards arrives intact.
- `RESULT_UART_TX_PARITY_EN` defined, byte 0x07 → parity bit = 1, frame is 44 cycles; byte 0x03 → parity bit = 0.
